// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared types, widths and lane helpers for the data-memory bus
package sys_bus_pkg;

    localparam int WAIT_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_B  = 3'd0,
        OP_H  = 3'd1,
        OP_W  = 3'd2,
        OP_BU = 3'd4,
        OP_HU = 3'd5
    } memop_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_HALT
    } router_state_t;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(input memop_t op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: byte_en = 4'b0001 << off;
            OP_H, OP_HU: byte_en = 4'b0011 << off;
            default:     byte_en = 4'b1111;
        endcase
    endfunction

    // Natural alignment check; unknown op encodings are never aligned.
    function automatic logic is_aligned(input memop_t op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: is_aligned = 1'b1;
            OP_H, OP_HU: is_aligned = ~off[0];
            OP_W:        is_aligned = (off == 2'b00);
            default:     is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sys_lsu_align.sv
// rtl/sys_lsu_align.sv - byte enables, store lane replication and load extension
import sys_bus_pkg::*;

module sys_lsu_align (
    input  logic [2:0]        op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext
);

    memop_t            mop;
    logic [DATA_W-1:0] shifted;

    assign mop     = memop_t'(op);
    assign shifted = rword >> {off, 3'b000};

    // Store side: enables plus data replicated across every lane of its size.
    always_comb begin
        be = byte_en(mop, off);
        case (mop)
            OP_B:    wdata_lane = {4{wdata[7:0]}};
            OP_H:    wdata_lane = {2{wdata[15:0]}};
            default: wdata_lane = wdata;
        endcase
    end

    // Load side: pull the addressed byte/halfword down to bit 0 and extend.
    always_comb begin
        case (mop)
            OP_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            OP_BU:   rdata_ext = {24'h0, shifted[7:0]};
            OP_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            OP_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = rword;
        endcase
    end

endmodule

// File: rtl/sys_dmem_router.sv
// rtl/sys_dmem_router.sv - CPU data port to address-mapped region router with sticky fault
import sys_bus_pkg::*;

module sys_dmem_router #(
    parameter int                          NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0]   REGION_MASK = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT = {4'd3, 4'd0}
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    input  logic                          req_we,
    input  logic [2:0]                    req_op,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          fault,
    output logic [31:0]                   fault_addr,
    output logic [NUM_REGIONS-1:0]        dev_sel,
    output logic [31:0]                   dev_addr,
    output logic                          dev_we,
    output logic [3:0]                    dev_be,
    output logic [DATA_W-1:0]             dev_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata
);

    router_state_t state, state_nxt;

    logic                   we_q;
    logic [2:0]             op_q;
    logic [1:0]             off_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [NUM_REGIONS-1:0] sel_q;
    logic [31:0]            dev_addr_q;
    logic [WAIT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [31:0]            fault_addr_q;
    logic                   halt_first_q;

    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [31:0]            hit_off;
    logic [WAIT_W-1:0]      hit_wait;
    logic                   op_legal;
    logic                   req_ok;
    logic                   accept;
    logic                   active;
    logic                   last;
    logic [DATA_W-1:0]      rword;
    logic [3:0]             be_w;
    logic [DATA_W-1:0]      wdata_lane_w;
    logic [DATA_W-1:0]      rdata_ext_w;

    // Region decode; walking downwards leaves the lowest matching region in place.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_off  = '0;
        hit_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((req_addr & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit_off    = req_addr & ~REGION_MASK[i*32 +: 32];
                hit_wait   = REGION_WAIT[i*4 +: 4];
            end
        end
    end

    // Legality: known op, no unsigned stores, naturally aligned, mapped.
    always_comb begin
        op_legal = (req_op == 3'd0) || (req_op == 3'd1) || (req_op == 3'd2) ||
                   (req_op == 3'd4) || (req_op == 3'd5);
        req_ok   = hit && op_legal && !(req_we && req_op[2]) &&
                   is_aligned(memop_t'(req_op), req_addr[1:0]);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; req_ready depends on state only.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        active    = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_ok ? ST_ACCESS : ST_HALT;
                end
            end
            ST_ACCESS: begin
                active = 1'b1;
                if (cnt_q == '0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_HALT: begin
                rsp_valid = halt_first_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign last = active && (cnt_q == '0);

    // Read word of the selected region, picked by the latched one-hot select.
    always_comb begin
        rword = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) rword = dev_rdata[i*DATA_W +: DATA_W];
        end
    end

    sys_lsu_align u_align (
        .op         (op_q),
        .off        (off_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .be         (be_w),
        .wdata_lane (wdata_lane_w),
        .rdata_ext  (rdata_ext_w)
    );

    // Request latch, wait counter, load capture and fault bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            op_q         <= 3'd0;
            off_q        <= 2'd0;
            wdata_q      <= '0;
            sel_q        <= '0;
            dev_addr_q   <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            fault_addr_q <= '0;
            halt_first_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                op_q       <= req_op;
                off_q      <= req_addr[1:0];
                wdata_q    <= req_wdata;
                sel_q      <= hit_sel;
                dev_addr_q <= hit_off;
                cnt_q      <= hit_wait;
                if (!req_ok) begin
                    fault_addr_q <= req_addr;
                    halt_first_q <= 1'b1;
                end
            end
            if (active && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (last) rdata_q <= we_q ? '0 : rdata_ext_w;
            if (state == ST_HALT) halt_first_q <= 1'b0;
        end
    end

    // Device-side outputs are only driven while an access is in flight.
    always_comb begin
        dev_sel   = active ? sel_q        : '0;
        dev_addr  = active ? dev_addr_q   : '0;
        dev_be    = active ? be_w         : 4'b0000;
        dev_wdata = active ? wdata_lane_w : '0;
        dev_we    = last && we_q;
        rsp_rdata = (state == ST_RESP) ? rdata_q : '0;
        fault     = (state == ST_HALT);
        fault_addr = fault_addr_q;
    end

endmodule

// File: doc/sys_dmem_router.md
# sys_dmem_router

Parametrised data-memory router between the CPU data port and NUM_REGIONS address-mapped targets (data RAM, MMIO devices). Accepts one load/store at a time over a valid/ready handshake and decodes the target region. Applies that region's fixed wait-state count, generates byte enables and lane-aligned write data, and returns aligned, sign/zero-extended load data. An unmapped, misaligned or illegal access raises a sticky fault and stops the port until reset, so the system top can derive halt/trap from it.

## Interface
- NUM_REGIONS, 2: number of target regions (1..8).
- REGION_BASE, {32'h1000_0000, 32'h0000_0000}: packed NUM_REGIONS×32 base addresses; region i is slice i.
- REGION_MASK, {32'hFFFF_F000, 32'hFFFF_0000}: packed NUM_REGIONS×32; set bits are compared, clear bits form the offset.
- REGION_WAIT, {4'd3, 4'd0}: packed NUM_REGIONS×4 wait cycles per region.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  router idle and accepting.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store.
- req_op  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (BU/HU are loads only).
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- fault  out  1  sticky fault flag.
- fault_addr  out  32  address of the faulting request.
- dev_sel  out  NUM_REGIONS  one-hot region select.
- dev_addr  out  32  req_addr & ~REGION_MASK[i].
- dev_we  out  1  single-cycle write strobe.
- dev_be  out  4  byte enables.
- dev_wdata  out  32  lane-replicated store data.
- dev_rdata  in  NUM_REGIONS×32  per-region read data.

## Operation
- States: IDLE, ACCESS, RESP, HALT.
- IDLE: req_ready=1. Accept on req_valid&&req_ready; latch addr, we, op, wdata.
- Decode happens at accept. The match is the lowest i where (req_addr & MASK[i]) == BASE[i].
- Fault conditions:
  - no region matches;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - op ∈ {3,6,7};
  - store with op 4 or 5.
- Fault path → HALT.
- Success path → ACCESS with a wait counter loaded with REGION_WAIT[i].
- ACCESS:
  - dev_sel, dev_addr, dev_be and dev_wdata are held stable.
  - The counter decrements each cycle; the last cycle is when it reads 0.
  - On the last cycle, dev_we=req_we, and dev_rdata[i] is sampled and aligned. Then → RESP.
- RESP: rsp_valid=1 for one cycle, all dev_* outputs 0, then → IDLE.
- HALT:
  - rsp_valid=1 and rsp_rdata=0 in the first HALT cycle only.
  - fault=1 and fault_addr are latched.
  - req_ready=0 and all dev_* outputs are 0 until reset.
- Byte enables, with off = addr[1:0]: B → 4'b0001<<off; H → 4'b0011<<off; W → 4'b1111.
- Store data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Load extraction: take the byte or halfword at off. B/H sign-extend; BU/HU zero-extend; W passes through.
- Reset mid-operation: the asynchronous return to IDLE means no further dev_we is issued and no rsp_valid is issued for the aborted request.

## Timing
- Reset values:
  - req_ready=1;
  - rsp_valid, fault, dev_we, dev_sel, dev_be = 0;
  - rsp_rdata, fault_addr, dev_addr, dev_wdata = 0.
- Request accepted at cycle T with W=REGION_WAIT[i]:
  - dev_sel active T+1..T+1+W;
  - dev_we only at T+1+W;
  - rsp_valid at T+2+W;
  - next accept no earlier than T+3+W.
- Fault accepted at T: rsp_valid and fault at T+1; fault stays 1 until reset.
- req_ready is a pure function of state (no combinational path from req_valid).
- dev_rdata is required to be valid in the last ACCESS cycle.

## Structure
- Package sys_bus_pkg:
  - memop_t enum (B, H, W, BU, HU);
  - WAIT_W=4;
  - DATA_W=32;
  - functions byte_en(op, off) and is_aligned(op, off).
- Sub-module sys_lsu_align (combinational): produces dev_be and dev_wdata for stores, and the extended rsp_rdata from a 32-bit word, op and offset.
- The FSM, decode and wait counter live in sys_dmem_router.

## Test plan
- LW 0x0000_0004, dev_rdata[0]=0x8899_AABB (W=0): dev_sel=01 and dev_be=1111 at T+1 → rsp_valid at T+2, rsp_rdata=0x8899_AABB.
- dev_rdata[0]=0x8011_2233:
  - LB 0x0000_0007 → 0xFFFF_FF80;
  - LBU 0x0000_0007 → 0x0000_0080;
  - LH 0x0000_0002 → 0xFFFF_8011.
- SH 0x1000_0012, wdata 0x0000_BEEF (W=3) →
  - dev_sel=10 for T+1..T+4, dev_addr=0x012, dev_be=1100, dev_wdata=0xBEEF_BEEF;
  - dev_we only at T+4;
  - rsp_valid at T+5 with rdata 0.
- LW 0x2000_0000 → fault=1 and rsp_valid at T+1, fault_addr=0x2000_0000, rsp_rdata=0; req_ready stays 0 for 20 cycles with req_valid held.
  - Repeat after reset with LH 0x0000_0001 → fault.
- Reset asserted at T+2 of the region-1 store above → dev_we never pulses, all outputs return to reset values. After release, LW 0x0000_0000 completes normally.
- req_valid held high with two region-1 LWs back to back → accepts at T and T+6, rsp_valid at T+5 and T+11.
